// File: rtl/player_pkg.sv
// player_pkg: facing codes, per-player key maps and start positions for player_motion.
package player_pkg;
  typedef enum logic [1:0] {DIR_N = 2'd0, DIR_S = 2'd1, DIR_E = 2'd2, DIR_W = 2'd3} dir_t;
  typedef struct packed {
    logic [7:0] up, down, left, right, aim_up, aim_down, aim_left, aim_right, fire;
  } keymap_t;
  // USB HID usage codes: WASD/arrows/space, IJKL/TGFH/enter, numpad, digit row
  localparam keymap_t KEYMAP [4] = '{
    '{8'h1A, 8'h16, 8'h04, 8'h07, 8'h52, 8'h51, 8'h50, 8'h4F, 8'h2C},
    '{8'h0C, 8'h0E, 8'h0D, 8'h0F, 8'h17, 8'h0A, 8'h09, 8'h0B, 8'h28},
    '{8'h60, 8'h5D, 8'h5C, 8'h5E, 8'h54, 8'h55, 8'h56, 8'h57, 8'h58},
    '{8'h1E, 8'h1F, 8'h20, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26}
  };
  localparam int START_X [4] = '{700, 2500, 700, 2500};
  localparam int START_Y [4] = '{400, 400, 2000, 2000};
  localparam dir_t START_DIR [4] = '{DIR_E, DIR_W, DIR_E, DIR_W};
  function automatic logic key_hit(input logic [31:0] kc, input logic [7:0] code);
    return code != 8'h00 &&
      (kc[7:0] == code || kc[15:8] == code || kc[23:16] == code || kc[31:24] == code);
  endfunction
endpackage

// File: rtl/player_motion_frame_sync.sv
// frame_sync: two-flop synchroniser plus edge flop for VGA_VS; one-clock tick per rising edge.
module frame_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic vs_i,
  output logic tick_o
);
  logic [2:0] sync_q;
  // all ones at reset so a sync already high at release never looks like an edge
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) sync_q <= 3'b111;
    else sync_q <= {sync_q[1:0], vs_i};
  assign tick_o = sync_q[1] & ~sync_q[2];
endmodule

// File: rtl/player_motion.sv
// player_motion: per-frame keyboard-driven movement, facing and optional firing for up to 4 players.
// Shot logic is built only when PLAYER_FIRE_EN is defined; otherwise fire is tied low.
module player_motion
  import player_pkg::*;
#(
  parameter int NUM_PLAYERS = 2,
  parameter int POS_W = 12,
  parameter int STEP = 2,
  parameter int X_MIN = 64,
  parameter int X_MAX = 3136,
  parameter int Y_MIN = 64,
  parameter int Y_MAX = 2336,
  parameter int COOLDOWN = 15
) (
  input  logic                                Clk,
  input  logic                                Reset,
  input  logic                                VGA_VS,
  input  logic [NUM_PLAYERS-1:0][31:0]        keycode,
  output logic [NUM_PLAYERS-1:0][POS_W-1:0]   pos_x,
  output logic [NUM_PLAYERS-1:0][POS_W-1:0]   pos_y,
  output logic [NUM_PLAYERS-1:0][1:0]         dir,
  output logic [NUM_PLAYERS-1:0]              moving,
  output logic [NUM_PLAYERS-1:0]              fire,
  output logic                                frame_tick
);
  localparam logic signed [POS_W:0] XLO = (POS_W+1)'(X_MIN);
  localparam logic signed [POS_W:0] XHI = (POS_W+1)'(X_MAX);
  localparam logic signed [POS_W:0] YLO = (POS_W+1)'(Y_MIN);
  localparam logic signed [POS_W:0] YHI = (POS_W+1)'(Y_MAX);
  localparam logic signed [POS_W:0] SD = (POS_W+1)'(STEP);
  frame_sync u_sync (.clk_i(Clk), .rst_i(Reset), .vs_i(VGA_VS), .tick_o(frame_tick));
  for (genvar i = 0; i < NUM_PLAYERS; i++) begin : g_pl
    localparam keymap_t KM = KEYMAP[i];
    logic up, dn, lf, rt;
    logic signed [POS_W:0] dx, dy, sx, sy;
    logic [POS_W-1:0] x_q, x_d, y_q, y_d;
    dir_t dir_q, dir_d;
    logic mov_q;
    always_comb begin
      up = key_hit(keycode[i], KM.up);
      dn = key_hit(keycode[i], KM.down);
      lf = key_hit(keycode[i], KM.left);
      rt = key_hit(keycode[i], KM.right);
      dx = (rt & ~lf) ? SD : (lf & ~rt) ? -SD : '0;
      dy = (dn & ~up) ? SD : (up & ~dn) ? -SD : '0;
      sx = $signed({1'b0, x_q}) + dx;
      sy = $signed({1'b0, y_q}) + dy;
      x_d = sx < XLO ? XLO[POS_W-1:0] : sx > XHI ? XHI[POS_W-1:0] : sx[POS_W-1:0];
      y_d = sy < YLO ? YLO[POS_W-1:0] : sy > YHI ? YHI[POS_W-1:0] : sy[POS_W-1:0];
      // aim keys win over movement keys; up > down > left > right in each group
      dir_d = key_hit(keycode[i], KM.aim_up)    ? DIR_N :
              key_hit(keycode[i], KM.aim_down)  ? DIR_S :
              key_hit(keycode[i], KM.aim_left)  ? DIR_W :
              key_hit(keycode[i], KM.aim_right) ? DIR_E :
              up ? DIR_N : dn ? DIR_S : lf ? DIR_W : rt ? DIR_E : dir_q;
    end
    always_ff @(posedge Clk or posedge Reset)
      if (Reset) begin
        x_q <= POS_W'(START_X[i]);
        y_q <= POS_W'(START_Y[i]);
        dir_q <= START_DIR[i];
        mov_q <= 1'b0;
      end else if (frame_tick) begin
        x_q <= x_d;
        y_q <= y_d;
        dir_q <= dir_d;
        mov_q <= (x_d != x_q) | (y_d != y_q);
      end
    assign pos_x[i] = x_q;
    assign pos_y[i] = y_q;
    assign dir[i] = dir_q;
    assign moving[i] = mov_q;
`ifdef PLAYER_FIRE_EN
    localparam int CW = $clog2(COOLDOWN + 2);
    logic [CW-1:0] cnt_q, cnt_d;
    logic fire_q, shoot;
    always_comb begin
      shoot = frame_tick && cnt_q == '0 && key_hit(keycode[i], KM.fire);
      cnt_d = shoot ? CW'(COOLDOWN) : (frame_tick && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
    end
    always_ff @(posedge Clk or posedge Reset)
      if (Reset) begin
        cnt_q <= '0;
        fire_q <= 1'b0;
      end else begin
        cnt_q <= cnt_d;
        fire_q <= shoot;
      end
    assign fire[i] = fire_q;
`else
    assign fire[i] = 1'b0;
`endif
  end
endmodule

// File: tb/tb_player_motion.sv
// tb_player_motion: random and directed frames for two players, checked per frame tick against a key-level model.
module tb_player_motion;
  localparam int NP = 2;
  localparam int CD = 3;
  logic Clk = 1'b0, Reset = 1'b1, VGA_VS = 1'b1;
  logic [NP-1:0][31:0] keycode = '0;
  logic [NP-1:0][11:0] pos_x, pos_y;
  logic [NP-1:0][1:0] dir;
  logic [NP-1:0] moving, fire;
  logic frame_tick;

  player_motion #(.NUM_PLAYERS(NP), .COOLDOWN(CD)) dut (
    .Clk(Clk), .Reset(Reset), .VGA_VS(VGA_VS), .keycode(keycode),
    .pos_x(pos_x), .pos_y(pos_y), .dir(dir), .moving(moving), .fire(fire),
    .frame_tick(frame_tick)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [NP-1:0][11:0] x, y;
    logic [NP-1:0][1:0] d;
    logic [NP-1:0] mv, fr;
  } exp_t;
  exp_t sb[$];
  int compared = 0, mismatched = 0, ticks_seen = 0, shots_seen = 0, frame_no = 0;
  int mx[NP], my[NP], md[NP], last_shot[NP];
  // order: up, down, left, right, aim up/down/left/right, fire
  localparam logic [7:0] KT [NP][9] = '{
    '{8'h1A, 8'h16, 8'h04, 8'h07, 8'h52, 8'h51, 8'h50, 8'h4F, 8'h2C},
    '{8'h0C, 8'h0E, 8'h0D, 8'h0F, 8'h17, 8'h0A, 8'h09, 8'h0B, 8'h28}
  };
  localparam int SX [NP] = '{700, 2500};
  localparam int SY [NP] = '{400, 400};
  localparam int SDIR [NP] = '{2, 3};
  localparam int DV [8] = '{0, 1, 3, 2, 0, 1, 3, 2};
  localparam int ORDER [8] = '{4, 5, 6, 7, 0, 1, 2, 3};
`ifdef PLAYER_FIRE_EN
  localparam bit FIRE_ON = 1'b1;
`else
  localparam bit FIRE_ON = 1'b0;
`endif

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic bit pr(int p, int k);
    logic [7:0] c;
    c = KT[p][k];
    if (c == 8'h00) return 1'b0;
    for (int b = 0; b < 4; b++) if (keycode[p][8*b +: 8] == c) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int clamp(int v, int lo, int hi);
    return v < lo ? lo : v > hi ? hi : v;
  endfunction

  function automatic logic [NP-1:0][31:0] k2(input logic [31:0] a, input logic [31:0] b);
    return {b, a};
  endfunction

  function automatic logic [7:0] rbyte();
    int r;
    r = $urandom_range(0, 9);
    if (r < 4) return 8'h00;
    if (r < 9) return KT[$urandom_range(0, NP-1)][$urandom_range(0, 8)];
    return 8'($urandom);
  endfunction

  task automatic model_reset();
    for (int p = 0; p < NP; p++) begin
      mx[p] = SX[p];
      my[p] = SY[p];
      md[p] = SDIR[p];
      last_shot[p] = -100;
    end
  endtask

  task automatic frame(input logic [NP-1:0][31:0] kc);
    exp_t e;
    int nx, ny;
    bit found;
    e = '0;
    keycode = kc;
    frame_no++;
    for (int p = 0; p < NP; p++) begin
      nx = clamp(mx[p] + 2 * (int'(pr(p, 3)) - int'(pr(p, 2))), 64, 3136);
      ny = clamp(my[p] + 2 * (int'(pr(p, 1)) - int'(pr(p, 0))), 64, 2336);
      found = 1'b0;
      for (int j = 0; j < 8; j++)
        if (!found && pr(p, ORDER[j])) begin
          md[p] = DV[ORDER[j]];
          found = 1'b1;
        end
      e.mv[p] = (nx != mx[p]) || (ny != my[p]);
      if (FIRE_ON && pr(p, 8) && frame_no - last_shot[p] >= CD + 1) begin
        e.fr[p] = 1'b1;
        last_shot[p] = frame_no;
      end
      mx[p] = nx;
      my[p] = ny;
      e.x[p] = nx[11:0];
      e.y[p] = ny[11:0];
      e.d[p] = md[p][1:0];
    end
    sb.push_back(e);
    VGA_VS = 1'b1;
    repeat (4) @(negedge Clk);
    VGA_VS = 1'b0;
    repeat (4) @(negedge Clk);
  endtask

  // monitor: each tick, compare the state one clock later against the oldest expectation
  initial forever begin
    @(negedge Clk);
    if (frame_tick) begin
      ticks_seen++;
      @(negedge Clk);
      chk("tick_width", frame_tick, 1'b0);
      if (sb.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_tick: got a tick with no frame pending at %0t", $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("frame_state", {pos_x, pos_y, dir, moving, fire}, e);
        shots_seen += int'(fire[0]);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1);
  end

  initial begin
    int s0, t0;
    model_reset();
    repeat (3) @(negedge Clk);
    chk("rst_pos_x", pos_x, {12'd2500, 12'd700});
    chk("rst_pos_y", pos_y, {12'd400, 12'd400});
    chk("rst_dir", dir, {2'd3, 2'd2});
    chk("rst_moving", moving, 2'b00);
    chk("rst_fire", fire, 2'b00);
    chk("rst_tick", frame_tick, 1'b0);
    Reset = 1'b0;
    repeat (8) @(negedge Clk);
    chk("vs_high_release", ticks_seen, 0);
    VGA_VS = 1'b0;
    repeat (4) @(negedge Clk);
    repeat (10) frame(k2(32'h07, 32'h0));
    chk("right10_x", pos_x[0], 12'd720);
    chk("right10_dir", dir[0], 2'd2);
    chk("right10_mov", moving[0], 1'b1);
    while (mx[0] < 3134) frame(k2(32'h07, 32'h0));
    chk("near_wall_x", pos_x[0], 12'd3134);
    repeat (3) frame(k2(32'h07, 32'h0));
    chk("wall_x", pos_x[0], 12'd3136);
    chk("wall_mov", moving[0], 1'b0);
    repeat (3) frame(k2(32'h1A0407, 32'h0));
    chk("lr_up_x", pos_x[0], 12'd3136);
    chk("lr_up_y", pos_y[0], 12'd394);
    chk("lr_up_dir", dir[0], 2'd0);
    repeat (3) frame(k2(32'h0, 32'h170F));
    chk("aim_x", pos_x[1], 12'd2506);
    chk("aim_dir", dir[1], 2'd0);
    repeat (2) frame(k2(32'h0, 32'h0));
    chk("release_dir", dir[1], 2'd0);
    chk("release_mov", moving[1], 1'b0);
    s0 = shots_seen;
    repeat (9) frame(k2(32'h2C, 32'h0));
    chk("fire_count", shots_seen - s0, FIRE_ON ? 3 : 0);
    t0 = ticks_seen;
    VGA_VS = 1'b1;
    @(posedge Clk);
    #1 Reset = 1'b1;
    #1;
    chk("midrst_x", pos_x, {12'd2500, 12'd700});
    chk("midrst_y", pos_y, {12'd400, 12'd400});
    chk("midrst_dir", dir, {2'd3, 2'd2});
    model_reset();
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    repeat (8) @(negedge Clk);
    chk("midrst_no_tick", ticks_seen, t0);
    VGA_VS = 1'b0;
    repeat (4) @(negedge Clk);
    repeat (300) frame(k2({rbyte(), rbyte(), rbyte(), rbyte()}, {rbyte(), rbyte(), rbyte(), rbyte()}));
    repeat (10) @(negedge Clk);
    chk("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
